// File: rtl/mac_seq_ctrl.sv
// Layer-job sequencer for a single mac_unit PE: clears the PE, streams K operand pairs,
// injects the bias, waits out relu/quantise, captures the result and repeats for N outputs.
module mac_seq_ctrl #(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 12,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [3:0]        cfg_conv_num_i,
    input  logic              cfg_relu_en_i,
    input  logic              cfg_partial_en_i,
    input  logic [LEN_W-1:0]  cfg_kernel_len_i,
    input  logic [CNT_W-1:0]  cfg_num_out_i,
    input  logic [ADDR_W-1:0] cfg_feat_base_i,
    input  logic [ADDR_W-1:0] cfg_wgt_base_i,
    input  logic [ADDR_W-1:0] cfg_bias_base_i,
    output logic              feat_rd_o,
    output logic              wgt_rd_o,
    output logic [ADDR_W-1:0] feat_addr_o,
    output logic [ADDR_W-1:0] wgt_addr_o,
    output logic              rst_n_pe_o,
    output logic              feature_valid_o,
    output logic              weight_valid_o,
    output logic              relu_en_o,
    output logic              partial_en_o,
    output logic [3:0]        conv_num_o,
    output logic              out_valid_o,
    output logic [CNT_W-1:0]  out_idx_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_MAC,
        S_BIAS,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    state_t            state_q;
    logic [LEN_W-1:0]  kernel_len_q;
    logic [LEN_W-1:0]  k_q;
    logic [CNT_W-1:0]  num_out_q;
    logic [CNT_W-1:0]  n_q;
    logic [1:0]        wait_q;
    logic [ADDR_W-1:0] feat_base_q;
    logic [ADDR_W-1:0] wgt_ptr_q;
    logic [ADDR_W-1:0] bias_ptr_q;

    logic              feat_rd_q;
    logic              wgt_rd_q;
    logic [ADDR_W-1:0] feat_addr_q;
    logic [ADDR_W-1:0] wgt_addr_q;
    logic              rst_n_pe_q;
    logic              feature_valid_q;
    logic              weight_valid_q;
    logic              relu_en_q;
    logic              partial_en_q;
    logic [3:0]        conv_num_q;
    logic              out_valid_q;
    logic [CNT_W-1:0]  out_idx_q;
    logic              busy_q;
    logic              done_q;

    logic k_zero;
    logic last_k;
    logic last_n;

    assign k_zero = (kernel_len_q == '0);
    assign last_k = (k_q == kernel_len_q - LEN_ONE);
    assign last_n = (n_q == num_out_q - CNT_ONE);

    // Weight and bias pointers post-increment on every issue, so weights stay contiguous
    // across outputs (wgt_base + n*K + k) without a multiplier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            kernel_len_q    <= '0;
            k_q             <= '0;
            num_out_q       <= '0;
            n_q             <= '0;
            wait_q          <= '0;
            feat_base_q     <= '0;
            wgt_ptr_q       <= '0;
            bias_ptr_q      <= '0;
            feat_rd_q       <= 1'b0;
            wgt_rd_q        <= 1'b0;
            feat_addr_q     <= '0;
            wgt_addr_q      <= '0;
            rst_n_pe_q      <= 1'b0;
            feature_valid_q <= 1'b0;
            weight_valid_q  <= 1'b0;
            relu_en_q       <= 1'b0;
            partial_en_q    <= 1'b0;
            conv_num_q      <= '0;
            out_valid_q     <= 1'b0;
            out_idx_q       <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            feature_valid_q <= feat_rd_q;
            weight_valid_q  <= wgt_rd_q;
            feat_rd_q       <= 1'b0;
            wgt_rd_q        <= 1'b0;
            out_valid_q     <= 1'b0;
            done_q          <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    busy_q     <= 1'b0;
                    rst_n_pe_q <= 1'b0;
                    if (start_i) begin
                        kernel_len_q <= cfg_kernel_len_i;
                        num_out_q    <= cfg_num_out_i;
                        feat_base_q  <= cfg_feat_base_i;
                        wgt_ptr_q    <= cfg_wgt_base_i;
                        bias_ptr_q   <= cfg_bias_base_i;
                        relu_en_q    <= cfg_relu_en_i;
                        partial_en_q <= cfg_partial_en_i;
                        conv_num_q   <= cfg_conv_num_i;
                        n_q          <= '0;
                        busy_q       <= 1'b1;
                        state_q      <= S_CLEAR;
                    end
                end

                S_CLEAR: begin
                    if (num_out_q == '0) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (k_zero) begin
                        wgt_rd_q   <= 1'b1;
                        wgt_addr_q <= bias_ptr_q;
                        bias_ptr_q <= bias_ptr_q + ADDR_ONE;
                        rst_n_pe_q <= 1'b1;
                        state_q    <= S_BIAS;
                    end else begin
                        k_q         <= '0;
                        feat_rd_q   <= 1'b1;
                        wgt_rd_q    <= 1'b1;
                        feat_addr_q <= feat_base_q;
                        wgt_addr_q  <= wgt_ptr_q;
                        wgt_ptr_q   <= wgt_ptr_q + ADDR_ONE;
                        rst_n_pe_q  <= 1'b1;
                        state_q     <= S_MAC;
                    end
                end

                S_MAC: begin
                    if (last_k) begin
                        wgt_rd_q   <= 1'b1;
                        wgt_addr_q <= bias_ptr_q;
                        bias_ptr_q <= bias_ptr_q + ADDR_ONE;
                        state_q    <= S_BIAS;
                    end else begin
                        k_q         <= k_q + LEN_ONE;
                        feat_rd_q   <= 1'b1;
                        wgt_rd_q    <= 1'b1;
                        feat_addr_q <= feat_addr_q + ADDR_ONE;
                        wgt_addr_q  <= wgt_ptr_q;
                        wgt_ptr_q   <= wgt_ptr_q + ADDR_ONE;
                    end
                end

                S_BIAS: begin
                    wait_q  <= '0;
                    state_q <= S_WAIT;
                end

                // Three idle cycles cover the PE bias, relu and work steps.
                S_WAIT: begin
                    if (wait_q == 2'd2) begin
                        out_valid_q <= 1'b1;
                        out_idx_q   <= n_q;
                        rst_n_pe_q  <= 1'b0;
                        state_q     <= S_CAPTURE;
                    end else begin
                        wait_q <= wait_q + 2'd1;
                    end
                end

                S_CAPTURE: begin
                    if (last_n) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        n_q        <= n_q + CNT_ONE;
                        rst_n_pe_q <= 1'b1;
                        if (k_zero) begin
                            wgt_rd_q   <= 1'b1;
                            wgt_addr_q <= bias_ptr_q;
                            bias_ptr_q <= bias_ptr_q + ADDR_ONE;
                            state_q    <= S_BIAS;
                        end else begin
                            k_q         <= '0;
                            feat_rd_q   <= 1'b1;
                            wgt_rd_q    <= 1'b1;
                            feat_addr_q <= feat_base_q;
                            wgt_addr_q  <= wgt_ptr_q;
                            wgt_ptr_q   <= wgt_ptr_q + ADDR_ONE;
                            state_q     <= S_MAC;
                        end
                    end
                end

                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    busy_q     <= 1'b0;
                    rst_n_pe_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign feat_rd_o       = feat_rd_q;
    assign wgt_rd_o        = wgt_rd_q;
    assign feat_addr_o     = feat_addr_q;
    assign wgt_addr_o      = wgt_addr_q;
    assign rst_n_pe_o      = rst_n_pe_q;
    assign feature_valid_o = feature_valid_q;
    assign weight_valid_o  = weight_valid_q;
    assign relu_en_o       = relu_en_q;
    assign partial_en_o    = partial_en_q;
    assign conv_num_o      = conv_num_q;
    assign out_valid_o     = out_valid_q;
    assign out_idx_o       = out_idx_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: directed and random jobs compared cycle by cycle against a
// closed-form timeline of the job (cycle offset -> expected strobes and addresses).
module tb_mac_seq_ctrl;

    localparam int ADDR_W = 16;
    localparam int LEN_W  = 12;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start_i;
    logic [3:0]        cfg_conv_num_i;
    logic              cfg_relu_en_i;
    logic              cfg_partial_en_i;
    logic [LEN_W-1:0]  cfg_kernel_len_i;
    logic [CNT_W-1:0]  cfg_num_out_i;
    logic [ADDR_W-1:0] cfg_feat_base_i;
    logic [ADDR_W-1:0] cfg_wgt_base_i;
    logic [ADDR_W-1:0] cfg_bias_base_i;
    logic              feat_rd_o;
    logic              wgt_rd_o;
    logic [ADDR_W-1:0] feat_addr_o;
    logic [ADDR_W-1:0] wgt_addr_o;
    logic              rst_n_pe_o;
    logic              feature_valid_o;
    logic              weight_valid_o;
    logic              relu_en_o;
    logic              partial_en_o;
    logic [3:0]        conv_num_o;
    logic              out_valid_o;
    logic [CNT_W-1:0]  out_idx_o;
    logic              busy_o;
    logic              done_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mac_seq_ctrl #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_i          (start_i),
        .cfg_conv_num_i   (cfg_conv_num_i),
        .cfg_relu_en_i    (cfg_relu_en_i),
        .cfg_partial_en_i (cfg_partial_en_i),
        .cfg_kernel_len_i (cfg_kernel_len_i),
        .cfg_num_out_i    (cfg_num_out_i),
        .cfg_feat_base_i  (cfg_feat_base_i),
        .cfg_wgt_base_i   (cfg_wgt_base_i),
        .cfg_bias_base_i  (cfg_bias_base_i),
        .feat_rd_o        (feat_rd_o),
        .wgt_rd_o         (wgt_rd_o),
        .feat_addr_o      (feat_addr_o),
        .wgt_addr_o       (wgt_addr_o),
        .rst_n_pe_o       (rst_n_pe_o),
        .feature_valid_o  (feature_valid_o),
        .weight_valid_o   (weight_valid_o),
        .relu_en_o        (relu_en_o),
        .partial_en_o     (partial_en_o),
        .conv_num_o       (conv_num_o),
        .out_valid_o      (out_valid_o),
        .out_idx_o        (out_idx_o),
        .busy_o           (busy_o),
        .done_o           (done_o)
    );

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        rpe;
        logic        frd;
        logic        wrd;
        logic        ov;
        logic [15:0] fa;
        logic [15:0] wa;
        logic [15:0] idx;
    } exp_t;

    // Job timeline: t=0 is the start cycle, t=1 the clear, then each output occupies
    // K+5 cycles (K MAC, 1 bias, 3 wait, 1 capture), and done lands at t = 2 + N*(K+5).
    function automatic exp_t model(input int t, input int K, input int N,
                                   input logic [15:0] fb, input logic [15:0] wb,
                                   input logic [15:0] bb);
        exp_t e;
        int per, td, u, n, r;
        e   = '0;
        per = K + 5;
        td  = 2 + N * per;
        if (t < 1 || t > td) return e;
        e.busy = 1'b1;
        if (t == td) begin
            e.done = 1'b1;
            return e;
        end
        if (t == 1) return e;
        e.rpe = 1'b1;
        u = t - 2;
        n = u / per;
        r = u % per;
        if (r < K) begin
            e.frd = 1'b1;
            e.wrd = 1'b1;
            e.fa  = fb + 16'(r);
            e.wa  = wb + 16'(n * K + r);
        end else if (r == K) begin
            e.wrd = 1'b1;
            e.wa  = bb + 16'(n);
        end else if (r == K + 4) begin
            e.ov  = 1'b1;
            e.idx = 16'(n);
            e.rpe = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle_check(input int t, input int K, input int N,
                               input logic [15:0] fb, input logic [15:0] wb,
                               input logic [15:0] bb, input logic [3:0] cv,
                               input logic relu, input logic part);
        exp_t e, p;
        int td;
        td = 2 + N * (K + 5);
        e  = model(t, K, N, fb, wb, bb);
        p  = model(t - 1, K, N, fb, wb, bb);
        chk($sformatf("busy@%0d", t), 32'(busy_o), 32'(e.busy));
        chk($sformatf("done@%0d", t), 32'(done_o), 32'(e.done));
        chk($sformatf("out_valid@%0d", t), 32'(out_valid_o), 32'(e.ov));
        if (e.ov) chk($sformatf("out_idx@%0d", t), 32'(out_idx_o), 32'(e.idx));
        if (t != td) chk($sformatf("rst_n_pe@%0d", t), 32'(rst_n_pe_o), 32'(e.rpe));
        chk($sformatf("feat_rd@%0d", t), 32'(feat_rd_o), 32'(e.frd));
        chk($sformatf("wgt_rd@%0d", t), 32'(wgt_rd_o), 32'(e.wrd));
        if (e.frd) chk($sformatf("feat_addr@%0d", t), 32'(feat_addr_o), 32'(e.fa));
        if (e.wrd) chk($sformatf("wgt_addr@%0d", t), 32'(wgt_addr_o), 32'(e.wa));
        chk($sformatf("feature_valid@%0d", t), 32'(feature_valid_o), 32'(p.frd));
        chk($sformatf("weight_valid@%0d", t), 32'(weight_valid_o), 32'(p.wrd));
        if (t >= 1) begin
            chk($sformatf("relu_en@%0d", t), 32'(relu_en_o), 32'(relu));
            chk($sformatf("partial_en@%0d", t), 32'(partial_en_o), 32'(part));
            chk($sformatf("conv_num@%0d", t), 32'(conv_num_o), 32'(cv));
        end
    endtask

    task automatic check_all_reset(input string tag);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_done"}, 32'(done_o), 32'd0);
        chk({tag, "_rst_n_pe"}, 32'(rst_n_pe_o), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid_o), 32'd0);
        chk({tag, "_rd"}, {30'd0, feat_rd_o, wgt_rd_o}, 32'd0);
        chk({tag, "_vld"}, {30'd0, feature_valid_o, weight_valid_o}, 32'd0);
        chk({tag, "_addr"}, {feat_addr_o, wgt_addr_o}, 32'd0);
        chk({tag, "_cfg"}, {26'd0, relu_en_o, partial_en_o, conv_num_o}, 32'd0);
        chk({tag, "_out_idx"}, 32'(out_idx_o), 32'd0);
    endtask

    // restart_t: cycle at which a competing start (with different cfg) is driven; 0 = none.
    // abort_t: cycle at which rst_n is pulled low mid-job; 0 = run to completion.
    task automatic run_job(input int K, input int N, input logic [15:0] fb,
                           input logic [15:0] wb, input logic [15:0] bb,
                           input logic [3:0] cv, input logic relu, input logic part,
                           input int restart_t, input int abort_t);
        int td;
        td = 2 + N * (K + 5);
        @(negedge clk);
        cycle_check(0, K, N, fb, wb, bb, cv, relu, part);
        cfg_kernel_len_i = LEN_W'(K);
        cfg_num_out_i    = CNT_W'(N);
        cfg_feat_base_i  = fb;
        cfg_wgt_base_i   = wb;
        cfg_bias_base_i  = bb;
        cfg_conv_num_i   = cv;
        cfg_relu_en_i    = relu;
        cfg_partial_en_i = part;
        start_i          = 1'b1;
        for (int t = 1; t <= td + 1; t++) begin
            @(negedge clk);
            cycle_check(t, K, N, fb, wb, bb, cv, relu, part);
            start_i = (t == restart_t);
            if (t == restart_t) begin
                cfg_conv_num_i   = ~cv;
                cfg_relu_en_i    = ~relu;
                cfg_partial_en_i = ~part;
                cfg_num_out_i    = CNT_W'(N + 1);
                cfg_feat_base_i  = ~fb;
            end
            if (t == abort_t) begin
                start_i = 1'b0;
                rst_n   = 1'b0;
                #1;
                check_all_reset("abort");
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk($sformatf("abort_done_%0d", i), 32'(done_o), 32'd0);
                    chk($sformatf("abort_ov_%0d", i), 32'(out_valid_o), 32'd0);
                    chk($sformatf("abort_busy_%0d", i), 32'(busy_o), 32'd0);
                    chk($sformatf("abort_rpe_%0d", i), 32'(rst_n_pe_o), 32'd0);
                end
                rst_n = 1'b1;
                return;
            end
        end
        start_i = 1'b0;
    endtask

    initial begin
        int K, N, td;
        logic [15:0] fb, wb, bb;
        logic [3:0] cv;

        rst_n            = 1'b0;
        start_i          = 1'b0;
        cfg_conv_num_i   = '0;
        cfg_relu_en_i    = 1'b0;
        cfg_partial_en_i = 1'b0;
        cfg_kernel_len_i = '0;
        cfg_num_out_i    = '0;
        cfg_feat_base_i  = '0;
        cfg_wgt_base_i   = '0;
        cfg_bias_base_i  = '0;
        #1;
        check_all_reset("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_job(3, 1, 16'h0010, 16'h0020, 16'h0030, 4'h5, 1'b1, 1'b0, 0, 0);
        run_job(2, 3, 16'h0010, 16'h0020, 16'h0030, 4'h9, 1'b0, 1'b1, 5, 0);
        run_job(0, 2, 16'h0010, 16'h0020, 16'h0030, 4'h3, 1'b1, 1'b1, 0, 0);
        run_job(4, 0, 16'h0100, 16'h0200, 16'h0300, 4'hC, 1'b1, 1'b0, 1, 0);
        run_job(3, 1, 16'hFFFF, 16'hFFFE, 16'hFFFF, 4'h1, 1'b0, 1'b0, 0, 0);
        run_job(3, 2, 16'h0040, 16'h0050, 16'h0060, 4'h7, 1'b1, 1'b1, 0, 11);
        run_job(2, 2, 16'h0011, 16'h0022, 16'h0033, 4'h2, 1'b0, 1'b1, 0, 0);

        for (int j = 0; j < 8; j++) begin
            K  = int'($urandom_range(0, 6));
            N  = int'($urandom_range(0, 3));
            fb = 16'($urandom);
            wb = 16'($urandom);
            bb = 16'($urandom);
            cv = 4'($urandom);
            td = 2 + N * (K + 5);
            run_job(K, N, fb, wb, bb, cv, 1'($urandom), 1'($urandom),
                    int'($urandom_range(0, td)), 0);
        end

        @(negedge clk);
        chk("final_idle_busy", 32'(busy_o), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
